adc_scan_sched: RTL and testbench
=================================

Name: adc_scan_sched

Overview:
- Scan sequencer for the 3-channel serial ADC acquisition path and its 4-way analog input mux, in the 60 MHz DSP clock domain.
- Steps the mux through the enabled inputs. For each input it waits for the mux to settle, issues an acquisition enable, and waits for the converter's completion flag.
- Stores the three 16-bit results per input in a 12-word result buffer. The DSP reads the buffer by address.
- Replaces free-running mux stepping with deterministic, maskable channel scheduling.

Parameters:
SETTLE_CYC, 120, clocks (2 us) between a mux_sel_out change and assertion of adc_start_out
START_W, 32, width of the adc_start_out pulse in clocks; must stay visible across at least two 5 MHz sample edges
TIMEOUT_CYC, 4096, WAIT_CONV timeout in clocks; used only with ACQ_TIMEOUT_EN

Ports:
dsp_clk_60M_in  in  1  sole clock, 60 MHz
dsp_rstn_in  in  1  reset, synchronous, active-low
scan_start_in  in  1  single-cycle pulse; starts a scan frame
scan_cont_in  in  1  level; 1 = restart a new frame automatically after DONE
scan_stop_in  in  1  single-cycle pulse; abort
chan_mask_in  in  4  bit n = 1 enables mux input n; sampled at frame start
conv_over_in  in  1  conversion-complete flag from the 5 MHz domain; asynchronous to the clock
adc_data1_in  in  16  ADC1 result; stable while conv_over_in is high
adc_data2_in  in  16  ADC2 result
adc_data3_in  in  16  ADC3 result
rd_addr_in  in  4  result buffer read address = {chan[1:0], adc[1:0]}; adc index 0..2; adc index 3 reads as 0
adc_start_out  out  1  acquisition enable to the ADC front end
mux_sel_out  out  2  analog mux select, driven to pt_MUX1 and pt_MUX2
busy_out  out  1  high in every state except IDLE
frame_done_out  out  1  one-cycle pulse when a frame completes
frame_cnt_out  out  8  count of completed frames; wraps 255 -> 0
err_timeout_out  out  1  sticky timeout flag
rd_data_out  out  16  buffer data, registered, 1-cycle read latency

Behaviour:
- Reset values: all outputs 0, mux_sel_out = 2'b00, buffer cleared to 0, FSM in IDLE.
- conv_over_in input conditioning: 2-flop synchronizer, then rising-edge detect. The detect output conv_evt is one clock wide.
- FSM states: IDLE, SETTLE, START, WAIT_CONV, STORE, NEXT, DONE.
- IDLE:
  - Action on scan_start_in with chan_mask_in != 0: latch the mask, set ch to the lowest enabled input, drive mux_sel_out = ch, go to SETTLE.
  - scan_start_in with mask = 0 is ignored; the FSM stays in IDLE.
- SETTLE: count SETTLE_CYC clocks, then go to START.
- START: adc_start_out = 1 for exactly START_W clocks, then go to WAIT_CONV.
- WAIT_CONV: conv_evt -> STORE. conv_evt seen in any other state is discarded.
- STORE: write adc_data1/2/3_in to buffer words {ch,00}, {ch,01}, {ch,10} in one clock, then go to NEXT.
- NEXT:
  - If a higher enabled input exists: ch = that input, mux_sel_out updated, go to SETTLE.
  - Otherwise go to DONE.
- DONE:
  - frame_done_out = 1 for one clock; frame_cnt_out increments.
  - If scan_cont_in = 1: re-latch the mask, ch = lowest enabled input, go to SETTLE.
  - If scan_cont_in = 1 and the new mask is 0: go to IDLE instead.
  - If scan_cont_in = 0: go to IDLE.
- scan_stop_in in any non-IDLE state:
  - Next state is IDLE; adc_start_out drops the next clock.
  - No frame_done_out pulse, frame_cnt_out unchanged, buffer keeps partial contents.
  - mux_sel_out holds its last value.
- Simultaneous scan_stop_in and scan_start_in: stop wins.
- scan_start_in while busy: ignored.
- Buffer reads:
  - A read of the address written in the same clock returns the old value (read-before-write).
  - Reads are allowed at any time.
- dsp_rstn_in low mid-scan: all state returns to reset values on the next clock edge.
- Per-channel latency, settle start to STORE: SETTLE_CYC + START_W + ADC conversion time + 2-3 clocks of synchronizer.

Optional Feature:
ACQ_TIMEOUT_EN
- Defined:
  - A WAIT_CONV counter runs up to TIMEOUT_CYC.
  - On expiry: err_timeout_out is set, the channel's three buffer words are written as 16'hFFFF, and the FSM goes to NEXT.
  - err_timeout_out is cleared only by an accepted scan_start_in or by reset.
- Undefined:
  - No counter; WAIT_CONV waits indefinitely; exit only via conv_evt, scan_stop_in or reset.
  - err_timeout_out is tied to 0.

Test Plan:
1. Mask 4'b1111, single start, ADC model returns 16'h1000+ch / 16'h2000+ch / 16'h3000+ch:
   - mux_sel_out steps 0,1,2,3.
   - Buffer addr 4'b0110 reads 16'h3001.
   - One frame_done_out pulse; frame_cnt_out = 1.
2. Mask 4'b1010: only inputs 1 and 3 are visited; input 0 and input 2 words stay 0.
3. Mask 4'b0000 with scan_start_in: busy_out stays 0; adc_start_out never asserts.
4. scan_cont_in = 1, mask 4'b0001, run 256 frames: frame_cnt_out wraps to 0; consecutive frame_done_out pulses are spaced by a full SETTLE+START+conversion period.
5. scan_stop_in during WAIT_CONV of input 2:
   - IDLE next clock; no frame_done_out pulse.
   - Input 0/1 data retained; a late conv_over_in is ignored.
6. ACQ_TIMEOUT_EN defined, conv_over_in held low on input 1:
   - After 4096 clocks, err_timeout_out = 1 and input 1 words = 16'hFFFF.
   - The scan continues to input 2.
   - The next scan_start_in clears the flag.

Source files
------------

// File: rtl/adc_scan_sched.sv
// Scan sequencer for the 3-ADC acquisition path behind a 4-way analog mux, with a 12-word result buffer.
// Optional WAIT_CONV timeout is enabled by defining ACQ_TIMEOUT_EN.
module adc_scan_sched #(
    parameter int SETTLE_CYC  = 120,
    parameter int START_W     = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        dsp_clk_60M_in,
    input  logic        dsp_rstn_in,
    input  logic        scan_start_in,
    input  logic        scan_cont_in,
    input  logic        scan_stop_in,
    input  logic [3:0]  chan_mask_in,
    input  logic        conv_over_in,
    input  logic [15:0] adc_data1_in,
    input  logic [15:0] adc_data2_in,
    input  logic [15:0] adc_data3_in,
    input  logic [3:0]  rd_addr_in,
    output logic        adc_start_out,
    output logic [1:0]  mux_sel_out,
    output logic        busy_out,
    output logic        frame_done_out,
    output logic [7:0]  frame_cnt_out,
    output logic        err_timeout_out,
    output logic [15:0] rd_data_out
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_START, S_WAIT, S_STORE, S_NEXT, S_DONE
    } state_t;

    state_t             r_state, w_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_mask;
    logic [1:0]         r_ch;
    logic [1:0]         r_mux;
    logic [7:0]         r_frames;
    logic [15:0]        r_rd;
    logic [15:0]        r_buf [12];
    logic               r_conv_s1, r_conv_s2, r_conv_d;

    logic               w_conv_evt, w_start_ok, w_stop, w_restart, w_timeout;
    logic [2:0]         w_hi;
    logic [3:0]         w_wr_base, w_rd_idx;

    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        f_lowest = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) f_lowest = 2'(i);
    endfunction

    // {found, index} of the lowest enabled input above ch
    function automatic logic [2:0] f_higher(input logic [3:0] m, input logic [1:0] ch);
        f_higher = 3'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i] && i > int'(ch)) f_higher = {1'b1, 2'(i)};
    endfunction

    assign w_conv_evt = r_conv_s2 & ~r_conv_d;
    assign w_start_ok = (r_state == S_IDLE) & scan_start_in & ~scan_stop_in & (|chan_mask_in);
    assign w_stop     = scan_stop_in & (r_state != S_IDLE);
    assign w_restart  = scan_cont_in & (|chan_mask_in);
    assign w_hi       = f_higher(r_mask, r_ch);
    assign w_wr_base  = {2'b00, r_ch} + {1'b0, r_ch, 1'b0};
    assign w_rd_idx   = {2'b00, rd_addr_in[3:2]} + {1'b0, rd_addr_in[3:2], 1'b0}
                      + {2'b00, rd_addr_in[1:0]};

`ifdef ACQ_TIMEOUT_EN
    assign w_timeout = (r_state == S_WAIT) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge dsp_clk_60M_in) begin
        if (!dsp_rstn_in) r_state <= S_IDLE;
        else              r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        if (w_stop) begin
            w_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_start_ok) w_nxt = S_SETTLE;
                S_SETTLE: if (r_cnt == CNT_W'(SETTLE_CYC - 1)) w_nxt = S_START;
                S_START:  if (r_cnt == CNT_W'(START_W - 1)) w_nxt = S_WAIT;
                S_WAIT:   if (w_conv_evt) w_nxt = S_STORE;
                          else if (w_timeout) w_nxt = S_NEXT;
                S_STORE:  w_nxt = S_NEXT;
                S_NEXT:   w_nxt = w_hi[2] ? S_SETTLE : S_DONE;
                S_DONE:   w_nxt = w_restart ? S_SETTLE : S_IDLE;
                default:  w_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        adc_start_out  = (r_state == S_START);
        busy_out       = (r_state != S_IDLE);
        frame_done_out = (r_state == S_DONE) & ~scan_stop_in;
    end

    // Phase counter restarts on every state change, so each timed state counts from 0
    always_ff @(posedge dsp_clk_60M_in) begin
        if (!dsp_rstn_in || w_nxt != r_state || r_state == S_IDLE) r_cnt <= '0;
        else                                                        r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge dsp_clk_60M_in) begin
        if (!dsp_rstn_in) begin
            r_conv_s1 <= 1'b0;
            r_conv_s2 <= 1'b0;
            r_conv_d  <= 1'b0;
        end else begin
            r_conv_s1 <= conv_over_in;
            r_conv_s2 <= r_conv_s1;
            r_conv_d  <= r_conv_s2;
        end
    end

    always_ff @(posedge dsp_clk_60M_in) begin
        if (!dsp_rstn_in) begin
            r_mask   <= 4'd0;
            r_ch     <= 2'd0;
            r_mux    <= 2'd0;
            r_frames <= 8'd0;
            r_rd     <= 16'd0;
            for (int i = 0; i < 12; i++) r_buf[i] <= 16'd0;
        end else begin
            if (w_start_ok) begin
                r_mask <= chan_mask_in;
                r_ch   <= f_lowest(chan_mask_in);
                r_mux  <= f_lowest(chan_mask_in);
            end
            if (!w_stop) begin
                if (r_state == S_NEXT && w_hi[2]) begin
                    r_ch  <= w_hi[1:0];
                    r_mux <= w_hi[1:0];
                end
                if (r_state == S_DONE) begin
                    r_frames <= r_frames + 8'd1;
                    if (w_restart) begin
                        r_mask <= chan_mask_in;
                        r_ch   <= f_lowest(chan_mask_in);
                        r_mux  <= f_lowest(chan_mask_in);
                    end
                end
                if (r_state == S_STORE) begin
                    r_buf[w_wr_base]        <= adc_data1_in;
                    r_buf[w_wr_base + 4'd1] <= adc_data2_in;
                    r_buf[w_wr_base + 4'd2] <= adc_data3_in;
                end
                if (w_timeout) begin
                    r_buf[w_wr_base]        <= 16'hFFFF;
                    r_buf[w_wr_base + 4'd1] <= 16'hFFFF;
                    r_buf[w_wr_base + 4'd2] <= 16'hFFFF;
                end
            end
            // Read samples the array before this edge's write lands
            r_rd <= (rd_addr_in[1:0] == 2'd3) ? 16'd0 : r_buf[w_rd_idx];
        end
    end

`ifdef ACQ_TIMEOUT_EN
    logic r_err;
    always_ff @(posedge dsp_clk_60M_in) begin
        if (!dsp_rstn_in)                r_err <= 1'b0;
        else if (w_start_ok)             r_err <= 1'b0;
        else if (w_timeout && !w_stop)   r_err <= 1'b1;
    end
    assign err_timeout_out = r_err;
`else
    assign err_timeout_out = 1'b0;
`endif

    assign mux_sel_out   = r_mux;
    assign frame_cnt_out = r_frames;
    assign rd_data_out   = r_rd;

endmodule

// File: tb/tb_adc_scan_sched.sv
// Scoreboard bench for adc_scan_sched: stimulus pushes expected mux steps, frame counts and read data;
// a monitor pops and compares whenever the DUT presents the matching event.
module tb_adc_scan_sched;
    localparam int SETTLE = 120;
    localparam int STARTW = 32;
    localparam int CONV   = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        scan_start = 1'b0, scan_cont = 1'b0, scan_stop = 1'b0;
    logic [3:0]  chan_mask = 4'd0;
    logic        conv_over = 1'b0;
    logic [15:0] d1 = 16'd0, d2 = 16'd0, d3 = 16'd0;
    logic [3:0]  rd_addr = 4'd0;
    logic        adc_start, busy, frame_done, err_to;
    logic [1:0]  mux_sel;
    logic [7:0]  frame_cnt;
    logic [15:0] rd_data;

    always #8 clk = ~clk;

    adc_scan_sched dut (
        .dsp_clk_60M_in(clk), .dsp_rstn_in(rstn),
        .scan_start_in(scan_start), .scan_cont_in(scan_cont), .scan_stop_in(scan_stop),
        .chan_mask_in(chan_mask), .conv_over_in(conv_over),
        .adc_data1_in(d1), .adc_data2_in(d2), .adc_data3_in(d3), .rd_addr_in(rd_addr),
        .adc_start_out(adc_start), .mux_sel_out(mux_sel), .busy_out(busy),
        .frame_done_out(frame_done), .frame_cnt_out(frame_cnt),
        .err_timeout_out(err_to), .rd_data_out(rd_data)
    );

    int n_chk = 0, n_fail = 0;
    logic [1:0]  mux_q[$];
    logic [7:0]  fc_q[$];
    logic [15:0] rd_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got an event, required none", nm);
    endtask

    // ADC front-end model: converts CONV clocks after the start pulse ends, unless that input is held
    int          hold_ch = -1;
    logic [15:0] dbase = 16'd0;
    int          cdl = 0, chi = 0;
    logic        adc_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (adc_prev && !adc_start && int'(mux_sel) != hold_ch) begin
            cdl = CONV;
        end else if (cdl > 0) begin
            cdl--;
            if (cdl == 0) begin
                d1 = 16'h1000 + dbase + 16'(mux_sel);
                d2 = 16'h2000 + dbase + 16'(mux_sel);
                d3 = 16'h3000 + dbase + 16'(mux_sel);
                conv_over = 1'b1;
                chi = 3;
            end
        end else if (chi > 0) begin
            chi--;
            if (chi == 0) conv_over = 1'b0;
        end
        adc_prev = adc_start;
    end

    // Monitor
    logic rd_req = 1'b0, rd_chk = 1'b0, fd_d = 1'b0, st_prev = 1'b0;
    int   cyc = 0, last_done = -1, first_gap = -1, gap;
    bit   chk_gap = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rd_chk) begin
            if (rd_q.size() == 0) unexpected("rd_data");
            else check("rd_data", rd_data, rd_q.pop_front());
        end
        rd_chk = rd_req;
        if (adc_start && !st_prev) begin
            if (mux_q.size() == 0) unexpected("adc_start");
            else check("mux_sel", mux_sel, mux_q.pop_front());
        end
        st_prev = adc_start;
        if (fd_d) begin
            if (fc_q.size() == 0) unexpected("frame_done");
            else check("frame_cnt", frame_cnt, fc_q.pop_front());
        end
        if (frame_done) begin
            if (chk_gap && last_done >= 0) begin
                gap = cyc - last_done;
                if (first_gap < 0) begin
                    first_gap = gap;
                    check("frame_period", 32'(gap > SETTLE + STARTW + CONV), 32'd1);
                end else begin
                    check("frame_gap", gap, first_gap);
                end
            end
            last_done = cyc;
        end
        fd_d = frame_done;
    end

    task automatic pulse_start(input logic [3:0] m);
        @(negedge clk);
        chan_mask = m;
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] exp);
        @(negedge clk);
        rd_addr = a;
        rd_req = 1'b1;
        rd_q.push_back(exp);
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!frame_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) unexpected("frame_done_timeout");
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_adc_start", adc_start, 1'b0);
        check("rst_mux_sel", mux_sel, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_frame_cnt", frame_cnt, 8'd0);
        check("rst_err", err_to, 1'b0);
        check("rst_rd_data", rd_data, 16'd0);
        rstn = 1'b1;

        // Empty mask: start ignored
        pulse_start(4'b0000);
        repeat (5) @(negedge clk);
        check("mask0_busy", busy, 1'b0);

        // Mask 1010: inputs 1 and 3 only
        mux_q.push_back(2'd1); mux_q.push_back(2'd3);
        fc_q.push_back(8'd1);
        pulse_start(4'b1010);
        wait_done(1000);
        rd(4'b0100, 16'h1001);
        rd(4'b0110, 16'h3001);
        rd(4'b1101, 16'h2003);
        rd(4'b0000, 16'h0000);
        rd(4'b1000, 16'h0000);
        rd(4'b1010, 16'h0000);

        // Mask 1111, with a start while busy that must be ignored
        mux_q.push_back(2'd0); mux_q.push_back(2'd1);
        mux_q.push_back(2'd2); mux_q.push_back(2'd3);
        fc_q.push_back(8'd2);
        pulse_start(4'b1111);
        repeat (20) @(negedge clk);
        pulse_start(4'b0001);
        wait_done(2000);
        rd(4'b0110, 16'h3001);
        rd(4'b0000, 16'h1000);
        rd(4'b1110, 16'h3003);
        rd(4'b1001, 16'h2002);
        rd(4'b0011, 16'h0000);
        check("no_timeout_err", err_to, 1'b0);

        // Stop during WAIT_CONV of input 2
        dbase = 16'h0100;
        hold_ch = 2;
        mux_q.push_back(2'd0); mux_q.push_back(2'd1); mux_q.push_back(2'd2);
        pulse_start(4'b1111);
        begin
            int n = 0;
            while (!(mux_sel == 2'd2 && adc_start) && n < 2000) begin @(negedge clk); n++; end
            while (adc_start && n < 2000) begin @(negedge clk); n++; end
            if (n >= 2000) unexpected("wait_conv2_timeout");
        end
        repeat (10) @(negedge clk);
        check("wait_busy", busy, 1'b1);
        scan_stop = 1'b1;
        @(negedge clk);
        scan_stop = 1'b0;
        check("stop_busy", busy, 1'b0);
        check("stop_mux_hold", mux_sel, 2'd2);
        conv_over = 1'b1;
        repeat (4) @(negedge clk);
        conv_over = 1'b0;
        repeat (5) @(negedge clk);
        check("late_conv_busy", busy, 1'b0);
        check("stop_frame_cnt", frame_cnt, 8'd2);
        rd(4'b0000, 16'h1100);
        rd(4'b0110, 16'h3101);
        rd(4'b1000, 16'h1002);
        rd(4'b1010, 16'h3002);
        hold_ch = -1;
        dbase = 16'h0000;

        // Reset, then 256 continuous frames on input 0
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst2_frame_cnt", frame_cnt, 8'd0);
        check("rst2_busy", busy, 1'b0);
        rstn = 1'b1;
        rd(4'b0110, 16'h0000);
        for (int k = 0; k < 256; k++) begin
            mux_q.push_back(2'd0);
            fc_q.push_back(8'(k + 1));
        end
        chk_gap = 1;
        last_done = -1;
        scan_cont = 1'b1;
        pulse_start(4'b0001);
        for (int k = 0; k < 255; k++) wait_done(600);
        scan_cont = 1'b0;
        wait_done(600);
        chk_gap = 0;
        repeat (3) @(negedge clk);
        check("wrap_busy", busy, 1'b0);
        check("wrap_frame_cnt", frame_cnt, 8'd0);

`ifdef ACQ_TIMEOUT_EN
        // Input 1 never converts: timeout fills FFFF and scan moves on to input 2
        hold_ch = 1;
        mux_q.push_back(2'd0); mux_q.push_back(2'd1); mux_q.push_back(2'd2);
        fc_q.push_back(8'd1);
        pulse_start(4'b0111);
        wait_done(6000);
        check("timeout_err", err_to, 1'b1);
        rd(4'b0100, 16'hFFFF);
        rd(4'b0101, 16'hFFFF);
        rd(4'b0110, 16'hFFFF);
        rd(4'b1001, 16'h2002);
        hold_ch = -1;
        mux_q.push_back(2'd0);
        fc_q.push_back(8'd2);
        pulse_start(4'b0001);
        check("timeout_clear", err_to, 1'b0);
        wait_done(600);
`endif

        repeat (4) @(negedge clk);
        check("mux_q_drained", mux_q.size(), 0);
        check("fc_q_drained", fc_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
